// File: rtl/reg_file.sv
// reg_file: architectural register file, two combinational read ports, two write ports, PC redirect on PC writes.
// Optional macro REG_FILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module reg_file #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_REG    = 15,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] rd_addr0,
    output logic [WIDTH-1:0]     rd_data0,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    output logic [WIDTH-1:0]     rd_data1,
    input  logic                 wr_en0,
    input  logic [ADDR_BITS-1:0] wr_addr0,
    input  logic [WIDTH-1:0]     wr_data0,
    input  logic                 wr_en1,
    input  logic [ADDR_BITS-1:0] wr_addr1,
    input  logic [WIDTH-1:0]     wr_data1,
    input  logic [WIDTH-1:0]     pc_in,
    output logic                 pc_wr_valid,
    output logic [WIDTH-1:0]     pc_wr_data
);
    localparam int unsigned          NUM_REGS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PC_IDX   = ADDR_BITS'(PC_REG);
    localparam logic [WIDTH-1:0]     PC_ADD   = WIDTH'(PC_OFFSET);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] pc_read;
    logic             wr_pc0;
    logic             wr_pc1;
    logic             pc_wr_valid_d, pc_wr_valid_q;
    logic [WIDTH-1:0] pc_wr_data_d,  pc_wr_data_q;

    assign pc_read = pc_in + PC_ADD;
    assign wr_pc0  = wr_en0 && (wr_addr0 == PC_IDX);
    assign wr_pc1  = wr_en1 && (wr_addr1 == PC_IDX);

    // One flop per index except the PC slot, which reads as a constant and is never selected.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == int'(PC_REG)) begin : g_pc
            assign regs[i] = '0;
        end else begin : g_gpr
            logic [WIDTH-1:0] reg_d, reg_q;

            always_comb begin
                reg_d = reg_q;
                if (wr_en1 && (wr_addr1 == ADDR_BITS'(i))) reg_d = wr_data1;
                if (wr_en0 && (wr_addr0 == ADDR_BITS'(i))) reg_d = wr_data0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) reg_q <= '0;
                else        reg_q <= reg_d;
            end

            assign regs[i] = reg_q;
        end
    end

    // Read port 0: PC index overrides everything, forwarding (if built) overrides storage.
    always_comb begin
        rd_data0 = regs[rd_addr0];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en1 && (wr_addr1 == rd_addr0)) rd_data0 = wr_data1;
        if (wr_en0 && (wr_addr0 == rd_addr0)) rd_data0 = wr_data0;
`endif
        if (rd_addr0 == PC_IDX) rd_data0 = pc_read;
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en1 && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
        if (wr_en0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
`endif
        if (rd_addr1 == PC_IDX) rd_data1 = pc_read;
    end

    // Redirect pulse: port 0 wins when both ports target the PC; data holds when idle.
    always_comb begin
        pc_wr_valid_d = wr_pc0 || wr_pc1;
        pc_wr_data_d  = pc_wr_data_q;
        if (wr_pc0)      pc_wr_data_d = wr_data0;
        else if (wr_pc1) pc_wr_data_d = wr_data1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wr_valid_q <= 1'b0;
            pc_wr_data_q  <= '0;
        end else begin
            pc_wr_valid_q <= pc_wr_valid_d;
            pc_wr_data_q  <= pc_wr_data_d;
        end
    end

    assign pc_wr_valid = pc_wr_valid_q;
    assign pc_wr_data  = pc_wr_data_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference model feeds a scoreboard queue that is drained at each sample point.
module tb_reg_file;
    localparam int unsigned AW  = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned PC  = 15;
    localparam int unsigned OFF = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [W-1:0]  rd_data0, rd_data1;
    logic          wr_en0, wr_en1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [W-1:0]  wr_data0, wr_data1;
    logic [W-1:0]  pc_in;
    logic          pc_wr_valid;
    logic [W-1:0]  pc_wr_data;

    always #5 clk = ~clk;

    reg_file #(.ADDR_BITS(AW), .WIDTH(W), .PC_REG(PC), .PC_OFFSET(OFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .pc_in(pc_in), .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
    );

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mdl [16];
    logic         exp_pv;
    logic [W-1:0] exp_pd;
    bit           bypass_en;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input string tag, input logic [W-1:0] got);
        if (exp_q.size() == 0) check_eq({tag, "/sb_empty"}, got, 'x);
        else                   check_eq(tag, got, exp_q.pop_front());
    endtask

    function automatic logic [W-1:0] mdl_rd(input logic [AW-1:0] a);
        return (a == AW'(PC)) ? pc_in + W'(OFF) : mdl[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        exp_pv = 1'b0;
        exp_pd = '0;
    endtask

    task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
        @(negedge clk);
        wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
        wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
    endtask

    // Take one edge, advance the model from the driven inputs, then check the redirect outputs.
    task automatic edge_chk(input string tag);
        logic h0, h1;
        @(posedge clk);
        if (rst_n) begin
            h0 = wr_en0 && (wr_addr0 == AW'(PC));
            h1 = wr_en1 && (wr_addr1 == AW'(PC));
            if (wr_en1 && !h1) mdl[wr_addr1] = wr_data1;
            if (wr_en0 && !h0) mdl[wr_addr0] = wr_data0;
            exp_pv = h0 || h1;
            if (h0)      exp_pd = wr_data0;
            else if (h1) exp_pd = wr_data1;
        end
        #1;
        sb_push(W'(exp_pv));
        sb_push(exp_pd);
        sb_pop({tag, "/pc_valid"}, W'(pc_wr_valid));
        sb_pop({tag, "/pc_data"}, pc_wr_data);
    endtask

    task automatic do_write(input string tag,
                            input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                            input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1);
        drive(e0, a0, d0, e1, a1, d1);
        edge_chk(tag);
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        wr_en0 = 1'b0; wr_en1 = 1'b0;
        rd_addr0 = a0; rd_addr1 = a1;
        sb_push(mdl_rd(a0));
        sb_push(mdl_rd(a1));
        #1;
        sb_pop({tag, "/rd0"}, rd_data0);
        sb_pop({tag, "/rd1"}, rd_data1);
    endtask

    initial begin
`ifdef REG_FILE_BYPASS_EN
        bypass_en = 1'b1;
`else
        bypass_en = 1'b0;
`endif
        rst_n = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        pc_in = 32'h100;
        model_reset();

        // Reset values
        #2;
        read_chk("reset", 4'd3, 4'd15);
        sb_push(W'(exp_pv)); sb_pop("reset/pc_valid", W'(pc_wr_valid));
        sb_push(exp_pd);     sb_pop("reset/pc_data", pc_wr_data);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read, every storage index
        do_write("w_r5", 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, '0);
        read_chk("rd_r5", 4'd5, 4'd15);
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) do_write("w_all", 1'b1, AW'(i), 32'hA5000000 | W'(i * 32'h00010101), 1'b0, '0, '0);
            else            do_write("w_all", 1'b0, '0, '0, 1'b1, AW'(i), 32'h5A000000 | W'(i * 32'h00010101));
        end
        for (int i = 0; i < 15; i++) read_chk("rd_all", AW'(i), AW'(14 - i));

        // Same-address collision: port 0 wins
        do_write("collide", 1'b1, 4'd7, 32'h11, 1'b1, 4'd7, 32'h22);
        do_write("p1_only", 1'b0, 4'd0, '0, 1'b1, 4'd8, 32'h33);
        read_chk("rd_collide", 4'd7, 4'd8);

        // PC redirect
        pc_in = 32'h2468;
        do_write("pc_p1", 1'b0, 4'd0, '0, 1'b1, 4'd15, 32'h2000);
        read_chk("rd_pc", 4'd15, 4'd7);
        do_write("pc_idle", 1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
        do_write("pc_both", 1'b1, 4'd15, 32'h3000, 1'b1, 4'd15, 32'h4000);
        do_write("pc_b2b", 1'b0, 4'd0, '0, 1'b1, 4'd15, 32'h5000);
        do_write("pc_mixed", 1'b1, 4'd15, 32'h6000, 1'b1, 4'd3, 32'h77);
        read_chk("rd_mixed", 4'd3, 4'd15);

        // Same-cycle write/read forwarding
        do_write("w_r2", 1'b1, 4'd2, 32'h10, 1'b0, 4'd0, '0);
        drive(1'b1, 4'd2, 32'hAA, 1'b1, 4'd9, 32'hB1);
        rd_addr0 = 4'd2; rd_addr1 = 4'd9;
        sb_push(bypass_en ? 32'hAA : mdl[2]);
        sb_push(bypass_en ? 32'hB1 : mdl[9]);
        #1;
        sb_pop("byp/rd0", rd_data0);
        sb_pop("byp/rd1", rd_data1);
        edge_chk("byp_edge");
        read_chk("byp_after", 4'd2, 4'd9);
        drive(1'b1, 4'd6, 32'hC0, 1'b1, 4'd6, 32'hC1);
        rd_addr0 = 4'd6; rd_addr1 = 4'd15;
        sb_push(bypass_en ? 32'hC0 : mdl[6]);
        sb_push(pc_in + W'(OFF));
        #1;
        sb_pop("byp_prio/rd0", rd_data0);
        sb_pop("byp_prio/rd1", rd_data1);
        edge_chk("byp_prio_edge");
        read_chk("byp_prio_after", 4'd6, 4'd2);

        // Asynchronous reset mid-operation
        do_write("w_r4", 1'b1, 4'd4, 32'h55, 1'b0, 4'd0, '0);
        read_chk("rd_r4", 4'd4, 4'd15);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        read_chk("async_rst", 4'd4, 4'd15);
        sb_push(W'(exp_pv)); sb_pop("async_rst/pc_valid", W'(pc_wr_valid));
        sb_push(exp_pd);     sb_pop("async_rst/pc_data", pc_wr_data);
        do_write("w_in_rst", 1'b1, 4'd4, 32'h77, 1'b1, 4'd15, 32'h9000);
        read_chk("rd_in_rst", 4'd4, 4'd5);
        @(negedge clk);
        rst_n = 1'b1;
        do_write("w_r4_post", 1'b1, 4'd4, 32'h66, 1'b0, 4'd0, '0);
        read_chk("rd_r4_post", 4'd4, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

- Architectural register file that sits directly upstream of the operand-select mux trees.
- Holds 2**ADDR_BITS registers of WIDTH bits; feeds two read ports into generalized muxes (`sel` = read address).
- Takes two write ports: port 0 is ALU/load result, port 1 is base-register writeback.
- Writes to the PC index are not stored; they emit a registered redirect pulse to fetch.

## Interface

Parameters:

- ADDR_BITS, 4, register index width; this is the select width of the downstream mux.
- WIDTH, 32, register width.
- PC_REG, 15, index of the program counter.
- PC_OFFSET, 8, value added to pc_in when PC_REG is read.

Ports:

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rd_addr0  input  ADDR_BITS  read port 0 index.
- rd_data0  output  WIDTH  read port 0 data, combinational.
- rd_addr1  input  ADDR_BITS  read port 1 index.
- rd_data1  output  WIDTH  read port 1 data, combinational.
- wr_en0  input  1  write port 0 enable.
- wr_addr0  input  ADDR_BITS  write port 0 index.
- wr_data0  input  WIDTH  write port 0 data.
- wr_en1  input  1  write port 1 enable.
- wr_addr1  input  ADDR_BITS  write port 1 index.
- wr_data1  input  WIDTH  write port 1 data.
- pc_in  input  WIDTH  current fetch PC.
- pc_wr_valid  output  1  registered one-cycle pulse: PC was written.
- pc_wr_data  output  WIDTH  registered redirect target, valid with pc_wr_valid.

## Operation

- Storage is 2**ADDR_BITS − 1 flops of WIDTH bits. No storage exists for PC_REG.
- Reads: rd_dataN = reg[rd_addrN], except rd_addrN == PC_REG returns pc_in + PC_OFFSET, truncated to WIDTH.
- Writes: at the rising edge, if wr_enN and wr_addrN != PC_REG, then reg[wr_addrN] <= wr_dataN.
- Same-address collision (both enables set, equal addresses): port 0 wins, port 1 is dropped. No error flag.
- PC write: at the rising edge, if any enabled port targets PC_REG, pc_wr_valid <= 1. pc_wr_data takes that port's data, with port 0 winning if both target PC_REG.
  - If no port targets PC_REG, pc_wr_valid <= 0 and pc_wr_data holds its previous value.
- Back-to-back PC writes produce back-to-back pulses; there is no suppression.
- Reset (rst_n low, asynchronous, any time including mid-write):
  - All registers <= 0, pc_wr_valid <= 0, pc_wr_data <= 0.
  - During reset, reads of non-PC indices return 0; reads of PC_REG still return pc_in + PC_OFFSET.
  - A write whose edge coincides with reset assertion is lost.

## Timing

- Read latency: 0 cycles, combinational from rd_addr and stored state.
- Write latency: data written at edge k is visible on reads from just after edge k.
- pc_wr_valid: asserted for exactly the cycle following the edge that sampled the PC write.
- First write accepted: first rising edge after rst_n deasserts.
- Without bypass, a read of wr_addr in the same cycle as its write returns the old value.

## Configuration

REG_FILE_BYPASS_EN controls same-cycle write-to-read forwarding.

- Defined: if wr_enN is high, wr_addrN == rd_addrM, and the address != PC_REG, then rd_dataM = wr_dataN combinationally in the same cycle.
  - Port 0 has priority over port 1, matching write priority.
  - Forwarding is active even while rst_n is low.
- Undefined: reads return only stored state (old value); no forwarding path exists.

## Test plan

1. Reset values: assert rst_n=0 with rd_addr0=3 and pc_in=0x100 on rd_addr1=15 → rd_data0=0, rd_data1=0x108, pc_wr_valid=0.
2. Write then read: write 0xDEADBEEF to r5 via port 0 → the next cycle rd_addr0=5 reads 0xDEADBEEF. Repeat for every index 0..14 with unique data and confirm no aliasing.
3. Collision: in one cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22 → r7 reads 0x11. Port 1 writing r8=0x33 alone → r8 reads 0x33.
4. PC redirect: port 1 writes r15=0x2000 → r15 read still gives pc_in+8, and the next cycle pc_wr_valid=1, pc_wr_data=0x2000. The cycle after that, pc_wr_valid=0 and pc_wr_data still 0x2000.
5. Bypass: port 0 writes r2=0xAA while rd_addr0=2 in the same cycle.
   - With REG_FILE_BYPASS_EN: rd_data0=0xAA that cycle.
   - Without it: old value that cycle, 0xAA the next.
6. Mid-operation reset: r4=0x55, then drop rst_n between edges → rd_data for r4 goes to 0 immediately, with no clock edge. Release rst_n, and the first edge write of r4=0x66 reads back 0x66.
